// File: rtl/board_pkg.sv
// Shared types and defaults for the board loader and its counter.
package board_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RUN    = 2'd3
  } loader_state_t;

  localparam int DEFAULT_BOARD_WIDTH  = 32;
  localparam int DEFAULT_BOARD_HEIGHT = 32;
  localparam int DEFAULT_COUNT_WIDTH  = 16;

  // A one-row board still needs a 1-bit index port.
  function automatic int row_idx_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/board_loader_step_counter.sv
// Loadable down-counter with zero flag; load/decrement take effect on the next edge.
// No backpressure: dec is ignored once the count reaches zero.
module step_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   dec,
  output logic                   zero
);

  logic [COUNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - COUNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/board_loader.sv
// Assembles a board image row by row, commits it with set_state, and sequences N-cycle runs.
// Rows accepted when row_ready (IDLE/LOAD); commit pulse one cycle after the last row; no input queueing.
module board_loader
  import board_pkg::*;
#(
  parameter int BOARD_WIDTH  = DEFAULT_BOARD_WIDTH,
  parameter int BOARD_HEIGHT = DEFAULT_BOARD_HEIGHT,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
  localparam int RIW         = row_idx_width(BOARD_HEIGHT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BOARD_WIDTH-1:0]            row_data,
  input  logic                              row_valid,
  output logic                              row_ready,
  input  logic                              load_abort,
  input  logic                              gen_start,
  input  logic [COUNT_WIDTH-1:0]            gen_count,
  output logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] new_board_state,
  output logic                              set_state,
  output logic                              generate_state,
  output logic                              busy,
  output logic                              gen_done,
  output logic [RIW-1:0]                    row_index
);

  localparam logic [RIW-1:0] LAST_ROW = RIW'(BOARD_HEIGHT - 1);

  loader_state_t state, state_nxt;
  logic [RIW-1:0] idx_nxt;
  logic           row_acc;
  logic           row_wr;
  logic           done_nxt;
  logic           cnt_load;
  logic           cnt_dec;
  logic           cnt_zero;

  assign row_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign row_acc   = row_valid && row_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      row_index      <= '0;
      set_state      <= 1'b0;
      generate_state <= 1'b0;
      gen_done       <= 1'b0;
    end else begin
      state          <= state_nxt;
      row_index      <= idx_nxt;
      set_state      <= (state_nxt == ST_COMMIT);
      generate_state <= (state_nxt == ST_RUN);
      gen_done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = row_index;
    row_wr    = 1'b0;
    done_nxt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      ST_IDLE, ST_LOAD: begin
        if (state == ST_LOAD && load_abort) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else if (row_acc) begin
          // row_index is always 0 in IDLE, so IDLE and LOAD share the row path
          row_wr = 1'b1;
          if (row_index == LAST_ROW) begin
            state_nxt = ST_COMMIT;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_LOAD;
            idx_nxt   = row_index + RIW'(1);
          end
        end else if (state == ST_IDLE && gen_start) begin
          if (gen_count == '0) begin
            done_nxt = 1'b1;
          end else begin
            cnt_load  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_RUN: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter holds N-1 so that zero marks the final RUN cycle.
  step_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (gen_count - COUNT_WIDTH'(1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_board_state <= '0;
    end else begin
      for (int r = 0; r < BOARD_HEIGHT; r++) begin
        if (row_wr && row_index == RIW'(r)) begin
          new_board_state[r*BOARD_WIDTH +: BOARD_WIDTH] <= row_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader with image and run-length scoreboards.
module tb_board_loader;
  localparam int BW = 32;
  localparam int BH = 32;
  localparam int CW = 16;
  localparam int IW = BW * BH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] row_data = '0;
  logic          row_valid = 1'b0;
  logic          row_ready;
  logic          load_abort = 1'b0;
  logic          gen_start = 1'b0;
  logic [CW-1:0] gen_count = '0;
  logic [IW-1:0] new_board_state;
  logic          set_state;
  logic          generate_state;
  logic          busy;
  logic          gen_done;
  logic [4:0]    row_index;

  board_loader #(.BOARD_WIDTH(BW), .BOARD_HEIGHT(BH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .load_abort(load_abort), .gen_start(gen_start),
    .gen_count(gen_count), .new_board_state(new_board_state),
    .set_state(set_state), .generate_state(generate_state), .busy(busy),
    .gen_done(gen_done), .row_index(row_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [IW-1:0] img_q[$];
  int            run_q[$];
  int set_cnt = 0, done_cnt = 0, gen_cyc = 0, busy_cyc = 0, run_len = 0;
  logic [IW-1:0] model = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: commit images and run lengths are matched against the scoreboards.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (set_state) begin
        set_cnt++;
        chk("set_expected", 32'(img_q.size() > 0), 32'd1);
        if (img_q.size() > 0) chk_img("commit_image", new_board_state, img_q.pop_front());
      end
      if (generate_state) begin
        gen_cyc++;
        run_len++;
      end
      if (busy) busy_cyc++;
      if (set_state && generate_state) chk("set_and_gen", 32'd1, 32'd0);
      if (gen_done) begin
        done_cnt++;
        chk("done_expected", 32'(run_q.size() > 0), 32'd1);
        if (run_q.size() > 0) chk("run_length", 32'(run_len), 32'(run_q.pop_front()));
        chk("gen_at_done", 32'(generate_state), 32'd0);
        run_len = 0;
      end
    end
  end

  task automatic load_rows(input int n, input logic [BW-1:0] base, input bit diag);
    for (int r = 0; r < n; r++) begin
      row_valid = 1'b1;
      row_data  = diag ? (32'h1 << r) : base;
      model[r*BW +: BW] = row_data;
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    chk(tag, 32'(done_cnt > d0), 32'd1);
  endtask

  initial begin
    int s0, d0, g0, b0;
    logic [IW-1:0] diag_img;
    logic [IW-1:0] ones_img;
    diag_img = '0;
    for (int r = 0; r < BH; r++) diag_img[r*33] = 1'b1;
    ones_img = '1;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_row_ready", 32'(row_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_set", 32'(set_state), 32'd0);
    chk("rst_gen", 32'(generate_state), 32'd0);
    chk("rst_done", 32'(gen_done), 32'd0);
    chk("rst_row_index", 32'(row_index), 32'd0);
    chk_img("rst_image", new_board_state, '0);

    // full diagonal load with row_valid held
    @(posedge clk); #1;
    load_rows(32, '0, 1'b1);
    img_q.push_back(model);
    @(negedge clk);
    chk("commit_set", 32'(set_state), 32'd1);
    chk("commit_ready", 32'(row_ready), 32'd0);
    chk("commit_busy", 32'(busy), 32'd1);
    chk("commit_idx", 32'(row_index), 32'd0);
    chk_img("diag_image", new_board_state, diag_img);
    @(negedge clk);
    chk("post_commit_set", 32'(set_state), 32'd0);
    chk("post_commit_busy", 32'(busy), 32'd0);
    chk("set_count1", 32'(set_cnt), 32'd1);

    // partial load, abort (with a simultaneous row that must be dropped)
    @(posedge clk); #1;
    load_rows(10, 32'hA5A5_5A5A, 1'b0);
    @(negedge clk);
    chk("partial_idx", 32'(row_index), 32'd10);
    chk("partial_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    load_abort = 1'b1; row_valid = 1'b1; row_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    load_abort = 1'b0; row_valid = 1'b0;
    @(negedge clk);
    chk("abort_idx", 32'(row_index), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk_img("abort_image", new_board_state, model);
    repeat (3) @(posedge clk);
    chk("abort_no_set", 32'(set_cnt), 32'd1);
    #1;
    load_rows(32, 32'hFFFF_FFFF, 1'b0);
    img_q.push_back(model);
    repeat (3) @(posedge clk);
    chk("set_count2", 32'(set_cnt), 32'd2);
    chk_img("ones_image", new_board_state, ones_img);

    // run of 5, with an ignored gen_start mid-run and gen_count changed
    #1;
    d0 = done_cnt; g0 = gen_cyc; b0 = busy_cyc;
    run_q.push_back(5);
    gen_start = 1'b1; gen_count = 16'd5;
    @(posedge clk); #1;
    gen_start = 1'b0; gen_count = 16'd77;
    @(negedge clk);
    chk("run_gen", 32'(generate_state), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_ready", 32'(row_ready), 32'd0);
    @(posedge clk); #1;
    gen_start = 1'b1; gen_count = 16'd3;
    @(posedge clk); #1;
    gen_start = 1'b0;
    wait_done(d0, "run5_timeout");
    repeat (3) @(posedge clk);
    chk("run5_gen_cycles", 32'(gen_cyc - g0), 32'd5);
    chk("run5_busy_cycles", 32'(busy_cyc - b0), 32'd5);
    chk("run5_done_count", 32'(done_cnt - d0), 32'd1);

    // N = 0
    #1;
    g0 = gen_cyc;
    run_q.push_back(0);
    gen_start = 1'b1; gen_count = 16'd0;
    @(posedge clk); #1;
    gen_start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(gen_done), 32'd1);
    chk("zero_gen", 32'(generate_state), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_drop", 32'(gen_done), 32'd0);
    chk("zero_gen_cycles", 32'(gen_cyc - g0), 32'd0);

    // row beats gen_start in the same IDLE cycle
    @(posedge clk); #1;
    g0 = gen_cyc; s0 = set_cnt;
    row_valid = 1'b1; row_data = 32'h1234_5678; gen_start = 1'b1; gen_count = 16'd4;
    model[0 +: BW] = row_data;
    @(posedge clk); #1;
    row_valid = 1'b0; gen_start = 1'b0;
    @(negedge clk);
    chk("race_busy", 32'(busy), 32'd1);
    chk("race_idx", 32'(row_index), 32'd1);
    chk("race_gen", 32'(generate_state), 32'd0);
    repeat (8) @(posedge clk);
    chk("race_no_gen", 32'(gen_cyc - g0), 32'd0);
    #1 load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
    @(negedge clk);
    chk_img("race_image", new_board_state, model);
    chk("race_no_set", 32'(set_cnt - s0), 32'd0);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    d0 = done_cnt;
    gen_start = 1'b1; gen_count = 16'd100;
    @(posedge clk); #1;
    gen_start = 1'b0;
    repeat (39) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_gen", 32'(generate_state), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_set", 32'(set_state), 32'd0);
    chk("arst_done", 32'(gen_done), 32'd0);
    chk("arst_idx", 32'(row_index), 32'd0);
    chk_img("arst_image", new_board_state, '0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("arst_ready", 32'(row_ready), 32'd1);
    chk("arst_busy_after", 32'(busy), 32'd0);
    repeat (120) @(posedge clk);
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("arst_gen_idle", 32'(generate_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_loader.md
# board_loader

Control stage directly upstream of `board`. Assembles a full board image from a stream of row-wide words (one row per handshake, driven by the AXI slave register logic) into a shadow register that drives `board`'s `new_board_state`, then commits it with a one-cycle `set_state` pulse. It also sequences evolution: on command it asserts `generate_state` for exactly N consecutive cycles and reports completion.

## Interface
Parameters:
- `BOARD_WIDTH`, default 32: cells per row; also the row word width.
- `BOARD_HEIGHT`, default 32: rows per board.
- `COUNT_WIDTH`, default 16: width of the generation count.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `row_data`  in  BOARD_WIDTH: row contents; bit x is the cell at column x.
- `row_valid`  in  1: `row_data` is valid.
- `row_ready`  out  1: the loader accepts a row this cycle.
- `load_abort`  in  1: discards a partial load.
- `gen_start`  in  1: starts a generation run.
- `gen_count`  in  COUNT_WIDTH: number of generations; sampled with `gen_start`.
- `new_board_state`  out  BOARD_WIDTH*BOARD_HEIGHT: shadow image driven to `board`.
- `set_state`  out  1: commit pulse to `board`.
- `generate_state`  out  1: step enable to `board`.
- `busy`  out  1: high in LOAD, COMMIT and RUN.
- `gen_done`  out  1: one-cycle pulse when a run ends.
- `row_index`  out  clog2(BOARD_HEIGHT): index of the next row to be written.

## Operation
- States: IDLE, LOAD, COMMIT, RUN.
- A row is accepted on a rising edge where `row_valid && row_ready`.
- `row_ready` = 1 in IDLE and LOAD, and 0 in COMMIT and RUN.
- An accepted row r writes `new_board_state[r*BOARD_WIDTH +: BOARD_WIDTH]`; `row_index` then increments.
- This mapping matches `board`'s cell index y*BOARD_WIDTH+x.
- IDLE, row accepted: write row 0 and go to LOAD. Go directly to COMMIT if BOARD_HEIGHT=1.
- LOAD, row accepted with `row_index`=BOARD_HEIGHT-1: write the row, wrap `row_index` to 0, go to COMMIT.
- COMMIT: `set_state`=1 for exactly one cycle, then go to IDLE.
- LOAD, `load_abort`=1: go to IDLE and set `row_index` to 0.
  - No `set_state` is issued.
  - Rows already written keep their values.
  - Abort has priority over a simultaneous row handshake; that row is not written.
- `load_abort` in any other state: ignored.
- IDLE, `gen_start`=1, `gen_count`=N>0: latch N and go to RUN. `generate_state`=1 in every RUN cycle.
- RUN: after N cycles, go to IDLE with `gen_done`=1 for one cycle.
- IDLE, `gen_start` with `gen_count`=0: no RUN, no `generate_state`; `gen_done` pulses the next cycle.
- IDLE, `row_valid` and `gen_start` together: the row wins and `gen_start` is dropped.
- `gen_start` outside IDLE: ignored. Changes to `gen_count` outside IDLE have no effect.
- The shadow register changes only on row writes. It never changes during COMMIT or RUN.
- `set_state` and `generate_state` are never high together.

## Timing
- Reset (asynchronous, any state): state=IDLE.
  - `new_board_state`, `row_index`, the run counter, `set_state`, `generate_state`, `busy` and `gen_done` all go to 0.
  - `row_ready`=1 once reset deasserts.
  - Reset mid-load or mid-run abandons the operation with no pulse.
- All outputs are registered. `row_ready` and `busy` are decoded from the state register.
- Last row accepted at edge k:
  - `set_state` is high during cycle k..k+1.
  - `new_board_state` already holds that row.
  - `board` captures at edge k+1.
- Full 32-row load with `row_valid` held high: 32 accept cycles plus 1 COMMIT, so the next row is accepted at edge 33.
- `gen_start` sampled at edge t with N>0:
  - `generate_state` is high from edge t to edge t+N, giving N sampling edges in `board`.
  - `gen_done` is high from edge t+N to edge t+N+1.
  - A new `gen_start` is accepted from edge t+N.
- N=0: `gen_done` is high from edge t to edge t+1.

## Structure
- Shared package `board_pkg` holds:
  - the state encoding typedef;
  - `DEFAULT_BOARD_WIDTH`=32, `DEFAULT_BOARD_HEIGHT`=32 and `DEFAULT_COUNT_WIDTH`=16;
  - the row index width function.
- One sub-module, `step_counter`: a loadable down-counter of width COUNT_WIDTH with a `zero` flag, used for the RUN length.
- Row write decode, the state machine and the shadow register stay in `board_loader`.

## Test plan
- Reset, then 32 rows with `row_data`=32'h1 << r and `row_valid` held high:
  - `set_state` pulses exactly once, in cycle 32;
  - `new_board_state` shows a diagonal (bit r*33 set for all r);
  - `row_ready`=0 during COMMIT.
- Load 10 rows, pulse `load_abort`, then load a full board of 32'hFFFF_FFFF:
  - no `set_state` occurs after the abort;
  - `row_index` returns to 0;
  - the final image is all ones and exactly one `set_state` pulse occurs.
- `gen_start` with `gen_count`=5:
  - `generate_state` is high for exactly 5 cycles;
  - `gen_done` pulses on the 6th;
  - `busy` is high for those 5 cycles.
- `gen_count`=0: no `generate_state`, and `gen_done` pulses one cycle after `gen_start`.
- `row_valid` and `gen_start` in the same IDLE cycle:
  - the row is accepted and the state goes to LOAD;
  - no `generate_state` follows.
  - `gen_start` asserted during RUN is also ignored.
- Assert `rst` asynchronously mid-RUN (`gen_count`=100, at cycle 40):
  - `generate_state` drops immediately;
  - no `gen_done` pulse occurs;
  - all outputs read 0, except `row_ready`=1 after release.
